fifo_read_packer: RTL and testbench



---
 rtl/fifo_pkg.sv | 31 +++
 rtl/stream_out_reg.sv | 56 +++++
 rtl/fifo_read_packer.sv | 144 ++++++++++++++
 tb/tb_fifo_read_packer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared constants and helpers for the FIFO read-side packer.
//                Provides the default entry width and pack ratio, the width
//                of a lane counter, and a count-to-keep-mask conversion.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int c_data_width_default   = 8;
    localparam int c_pack_ratio_default   = 4;
    // A lane counter must represent 0..PACK_RATIO inclusive.
    localparam int c_lane_count_w_default = $clog2(c_pack_ratio_default + 1);
    // Widest keep mask keep_mask() can build; callers narrow it with a size cast.
    localparam int c_keep_max             = 32;

    // Mask with the lower `count` bits set. For example, count 3 gives ...0111.
    function automatic logic [c_keep_max-1:0] keep_mask(input int count);
        logic [c_keep_max-1:0] v_mask;
        v_mask = '0;
        for (int i = 0; i < c_keep_max; i++) begin
            if (i < count) begin
                v_mask[i] = 1'b1;
            end
        end
        return v_mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_out_reg
//  Description : Single-entry valid/ready output register with a keep mask.
//                The producer asserts `load` only when the slot is free, which
//                means !out_valid || out_ready. Data and keep hold stable while
//                the word is stalled.
//  Ports       : clk, rst_n            - clock, asynchronous active-low reset
//                load                  - capture load_data/load_keep, raise valid
//                load_data, load_keep  - word to present
//                out_ready             - downstream ready
//                out_data, out_keep    - presented word and lane mask
//                out_valid             - stream valid
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_out_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [KEEP_WIDTH-1:0] load_keep,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [KEEP_WIDTH-1:0] out_keep,
    output logic                  out_valid
);

    logic [DATA_WIDTH-1:0] r_data;
    logic [KEEP_WIDTH-1:0] r_keep;
    logic                  r_valid;

    // A load in the accepting cycle takes priority, so valid stays high and
    // back-to-back words flow without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_keep  <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_data  <= load_data;
            r_keep  <= load_keep;
            r_valid <= 1'b1;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_data  = r_data;
    assign out_keep  = r_keep;
    assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/fifo_read_packer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_read_packer
//  Description : Pops DATA_WIDTH entries from fifo_top in the read domain and
//                packs PACK_RATIO consecutive entries into one wide word on a
//                valid/ready stream. The first popped entry goes to lane 0.
//                A flush pulse emits any partial word with a keep mask.
//  Ports       : read_clock, read_reset_n - clock, asynchronous active-low reset
//                fifo_empty, read_data    - FIFO status and data. Data is valid
//                                           one cycle after a pop.
//                read_enable              - pop request (combinational)
//                flush, flush_busy        - flush request pulse and busy status
//                out_data, out_keep,
//                out_valid, out_ready     - packed output stream
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_read_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width_default,
    parameter int PACK_RATIO = c_pack_ratio_default   // 2 .. c_keep_max
) (
    input  logic                             read_clock,
    input  logic                             read_reset_n,
    input  logic                             fifo_empty,
    input  logic [DATA_WIDTH-1:0]            read_data,
    output logic                             read_enable,
    input  logic                             flush,
    output logic                             flush_busy,
    output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
    output logic [PACK_RATIO-1:0]            out_keep,
    output logic                             out_valid,
    input  logic                             out_ready
);

    localparam int c_lane_w = $clog2(PACK_RATIO + 1);
    localparam int c_word_w = DATA_WIDTH * PACK_RATIO;

    logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] r_acc;
    logic [c_lane_w-1:0]                   r_lane_count;
    logic                                  r_pending;
    logic                                  r_flush_active;

    logic                w_slot_free;
    logic                w_acc_full;
    logic                w_xfer;
    logic                w_room;
    logic                w_flush_settled;
    logic                w_flush_partial;
    logic                w_flush_done;
    logic                w_load;
    logic [PACK_RATIO-1:0] w_load_keep;
    logic [c_word_w-1:0] w_load_data;
    logic [c_lane_w-1:0] w_cap_lane;
    logic [c_lane_w-1:0] w_lane_base;
    logic [c_lane_w-1:0] w_lane_next;

    // ------------------------------------------------------------------
    // Pop control
    // ------------------------------------------------------------------
    assign w_slot_free = !out_valid || out_ready;
    assign w_acc_full  = (r_lane_count == c_lane_w'(PACK_RATIO));
    assign w_xfer      = w_acc_full && w_slot_free;

    // An in-flight pop also reserves a lane. One extra bit keeps the sum from
    // wrapping when PACK_RATIO+1 is a power of two.
    assign w_room = ({1'b0, r_lane_count} + (c_lane_w + 1)'(r_pending))
                    < (c_lane_w + 1)'(PACK_RATIO);

    assign read_enable = !fifo_empty && !r_flush_active && (w_room || w_xfer);

    // ------------------------------------------------------------------
    // Flush control. It waits for any in-flight pop to land, then resolves
    // in one of three ways: nothing to send, a partial word, or a full
    // word sent through the normal transfer path.
    // ------------------------------------------------------------------
    assign w_flush_settled = r_flush_active && !r_pending;
    assign w_flush_partial = w_flush_settled && (r_lane_count != '0) && !w_acc_full
                             && w_slot_free;
    assign w_flush_done    = w_flush_settled
                             && ((r_lane_count == '0) || w_flush_partial || w_xfer);

    assign flush_busy = r_flush_active;

    // ------------------------------------------------------------------
    // Word assembly. The keep mask follows lane_count, so a full transfer
    // gives all ones. Lanes not yet filled are forced to zero.
    // ------------------------------------------------------------------
    assign w_load      = w_xfer || w_flush_partial;
    assign w_load_keep = PACK_RATIO'(keep_mask(int'(r_lane_count)));

    for (genvar g = 0; g < PACK_RATIO; g++) begin : g_lane
        assign w_load_data[g*DATA_WIDTH +: DATA_WIDTH] =
            w_load_keep[g] ? r_acc[g] : '0;
    end

    // A capture that coincides with a transfer starts the next word in lane 0.
    assign w_cap_lane  = w_xfer ? '0 : r_lane_count;
    assign w_lane_base = w_load ? '0 : r_lane_count;
    assign w_lane_next = w_lane_base + c_lane_w'(r_pending);

    always_ff @(posedge read_clock or negedge read_reset_n) begin
        if (!read_reset_n) begin
            r_acc          <= '0;
            r_lane_count   <= '0;
            r_pending      <= 1'b0;
            r_flush_active <= 1'b0;
        end else begin
            r_pending    <= read_enable;
            r_lane_count <= w_lane_next;
            for (int i = 0; i < PACK_RATIO; i++) begin
                if (r_pending && (w_cap_lane == c_lane_w'(i))) begin
                    r_acc[i] <= read_data;
                end
            end
            // A new flush request is ignored while one is already active.
            if (r_flush_active) begin
                r_flush_active <= !w_flush_done;
            end else begin
                r_flush_active <= flush;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    stream_out_reg #(
        .DATA_WIDTH (c_word_w),
        .KEEP_WIDTH (PACK_RATIO)
    ) u_stream_out_reg (
        .clk       (read_clock),
        .rst_n     (read_reset_n),
        .load      (w_load),
        .load_data (w_load_data),
        .load_keep (w_load_keep),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_valid (out_valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_read_packer
//  Description : Self-checking bench for fifo_read_packer. A behavioural FIFO
//                and packing model fills a scoreboard queue, and an
//                independent monitor checks every accepted output word
//                against that queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_read_packer;

    localparam int DW = 8;
    localparam int PR = 4;
    localparam int WW = DW * PR;

    typedef struct packed {
        logic [WW-1:0] data;
        logic [PR-1:0] keep;
    } word_t;

    logic          read_clock   = 1'b0;
    logic          read_reset_n = 1'b0;
    logic          fifo_empty   = 1'b1;
    logic [DW-1:0] read_data    = '0;
    logic          read_enable;
    logic          flush        = 1'b0;
    logic          flush_busy;
    logic [WW-1:0] out_data;
    logic [PR-1:0] out_keep;
    logic          out_valid;
    logic          out_ready    = 1'b0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] group_q[$];
    word_t         exp_q[$];
    logic [WW-1:0] last_data = '0;
    logic [PR-1:0] last_keep = '0;

    int checks   = 0;
    int failures = 0;

    fifo_read_packer #(
        .DATA_WIDTH (DW),
        .PACK_RATIO (PR)
    ) dut (
        .read_clock   (read_clock),
        .read_reset_n (read_reset_n),
        .fifo_empty   (fifo_empty),
        .read_data    (read_data),
        .read_enable  (read_enable),
        .flush        (flush),
        .flush_busy   (flush_busy),
        .out_data     (out_data),
        .out_keep     (out_keep),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    always #5 read_clock = ~read_clock;

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // The current group of popped entries becomes a word. The first entry is
    // the lowest byte, and keep has one bit per entry.
    function automatic word_t make_word();
        word_t w;
        w.data = '0;
        for (int i = 0; i < group_q.size(); i++) begin
            w.data = w.data | (WW'(group_q[i]) << (DW * i));
        end
        w.keep = PR'((1 << group_q.size()) - 1);
        return w;
    endfunction

    // Behavioural FIFO plus the packing reference model.
    initial begin : fifo_model
        logic will_pop;
        logic will_flush;
        forever begin
            @(negedge read_clock);
            will_pop   = read_reset_n && read_enable && !fifo_empty;
            will_flush = read_reset_n && flush && !flush_busy;
            if (read_reset_n) begin
                checks++;
                if (read_enable && (fifo_empty || flush_busy)) begin
                    failures++;
                    $display("FAIL pop_guard: read_enable=%b fifo_empty=%b flush_busy=%b at %0t",
                             read_enable, fifo_empty, flush_busy, $time);
                end
            end
            @(posedge read_clock);
            #1;
            if (will_pop) begin
                read_data = fifo_q.pop_front();
                group_q.push_back(read_data);
                if (group_q.size() == PR) begin
                    exp_q.push_back(make_word());
                    group_q.delete();
                end
            end
            if (will_flush && group_q.size() > 0) begin
                exp_q.push_back(make_word());
                group_q.delete();
            end
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Monitor: checks every accepted word in order and the hold rule during stalls.
    initial begin : monitor
        logic          stalled;
        logic [WW-1:0] held_data;
        logic [PR-1:0] held_keep;
        word_t         e;
        stalled = 1'b0;
        forever begin
            @(negedge read_clock);
            if (!read_reset_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    checks++;
                    if (!out_valid || out_data !== held_data || out_keep !== held_keep) begin
                        failures++;
                        $display("FAIL stall_hold: valid=%b data=%h keep=%h required valid=1 data=%h keep=%h",
                                 out_valid, out_data, out_keep, held_data, held_keep);
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_word: data=%h keep=%h required none", out_data, out_keep);
                    end else begin
                        e = exp_q.pop_front();
                        check("word_data", out_data, e.data);
                        check("word_keep", WW'(out_keep), WW'(e.keep));
                    end
                    last_data = out_data;
                    last_keep = out_keep;
                end
                stalled   = out_valid && !out_ready;
                held_data = out_data;
                held_keep = out_keep;
            end
        end
    end

    task automatic tick();
        @(posedge read_clock);
        #2;
    endtask

    task automatic push(input logic [DW-1:0] d);
        fifo_q.push_back(d);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || flush_busy || out_valid) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL drain_timeout: fifo=%0d expected_words=%0d busy=%b valid=%b required all idle",
                     fifo_q.size(), exp_q.size(), flush_busy, out_valid);
        end
        repeat (3) tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_out_valid"}, WW'(out_valid), '0);
        check({tag, "_out_data"}, out_data, '0);
        check({tag, "_out_keep"}, WW'(out_keep), '0);
        check({tag, "_flush_busy"}, WW'(flush_busy), '0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        // Reset state. The FIFO is empty first, then holds 8 entries.
        repeat (2) tick();
        @(negedge read_clock);
        check("reset_read_enable", WW'(read_enable), '0);
        check_outputs_zero("reset");
        tick();
        for (int i = 1; i <= 8; i++) push(DW'(i * 8'h11));
        repeat (3) tick();
        check_outputs_zero("reset_queued");
        #1 read_reset_n = 1'b1;
        out_ready = 1'b1;
        drain(100);
        check("basic_last_data", last_data, 32'h8877_6655);
        check("basic_last_keep", WW'(last_keep), WW'(4'hF));

        // Backpressure: one word is held in the output and one more fills the
        // accumulator.
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) push(DW'(8'h30 + i));
        repeat (20) tick();
        @(negedge read_clock);
        check("bp_read_enable", WW'(read_enable), '0);
        check("bp_fifo_left", WW'(fifo_q.size()), WW'(4));
        check("bp_out_valid", WW'(out_valid), WW'(1));
        tick();
        out_ready = 1'b1;
        drain(100);
        check("bp_last_data", last_data, 32'h3B3A_3938);

        // Partial word flush.
        push(8'hA1); push(8'hB2); push(8'hC3);
        repeat (6) tick();
        pulse_flush();
        drain(100);
        check("partial_data", last_data, 32'h00C3_B2A1);
        check("partial_keep", WW'(last_keep), WW'(4'b0111));

        // Flush with nothing to send: busy for exactly one cycle, no word.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge read_clock);
        check("empty_flush_busy_1", WW'(flush_busy), WW'(1));
        @(negedge read_clock);
        check("empty_flush_busy_0", WW'(flush_busy), '0);
        check("empty_flush_no_word", WW'(out_valid), '0);
        tick();

        // Flush sampled on the same edge as the second pop.
        push(8'h5A); push(8'hC6);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drain(100);
        check("flush_pop_data", last_data, 32'h0000_C65A);
        check("flush_pop_keep", WW'(last_keep), WW'(4'b0011));

        // Asynchronous reset mid-word: one word is stalled and two lanes are filled.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(DW'(8'h10 + i));
        repeat (14) tick();
        check("midword_valid", WW'(out_valid), WW'(1));
        #1 read_reset_n = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        group_q.delete();
        #1 check_outputs_zero("async_reset");
        repeat (2) tick();
        #1 read_reset_n = 1'b1;
        out_ready = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) push(DW'(8'h20 + i));
        drain(100);
        check("post_reset_data", last_data, 32'h2423_2221);
        check("post_reset_keep", WW'(last_keep), WW'(4'hF));

        // Randomised traffic, backpressure and flushes.
        for (int cyc = 0; cyc < 800; cyc++) begin
            tick();
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = !flush && ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 2) != 0 && fifo_q.size() < 16) begin
                push(DW'($urandom_range(0, 255)));
            end
        end
        flush     = 1'b0;
        out_ready = 1'b1;
        drain(200);
        pulse_flush();
        drain(200);
        check("final_group_empty", WW'(group_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
